// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned BURST_W = 8;

    // Grant index width; a single-bit index is kept even for tiny requester counts.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first active request after 'last', wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   nxt_c,
    output logic            any_req_c
);

    // Distance of each candidate from last+1; the smallest active distance wins.
    always_comb begin
        int unsigned best;
        int unsigned off;
        best      = NREQ;
        off       = 0;
        nxt_c     = last;
        any_req_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            off = (i + NREQ - 1 - 32'(last)) % NREQ;
            if (req[i] && (off < best)) begin
                best      = off;
                nxt_c     = IW'(i);
                any_req_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one synchronous FIFO write port among NREQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned BW       = 8,
    parameter  int unsigned LGFLEN   = 4,
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned MAXBURST = 4,
    localparam int unsigned IW       = idx_w(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*BW-1:0]   i_data,
    output logic [NREQ-1:0]      o_ack,
    output logic [IW-1:0]        o_grant,
    output logic                 o_busy,
    output logic                 o_fifo_wr,
    output logic [BW-1:0]        o_fifo_data,
    input  logic [LGFLEN:0]      i_fifo_fill,
    input  logic                 i_fifo_full
);

    localparam int unsigned DEPTH = 1 << LGFLEN;
    localparam int unsigned SW    = LGFLEN + 2;

    state_e               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic                 wr_q, wr_d;
    logic [BW-1:0]        data_q, data_d;

    logic [BW-1:0]        word_c [NREQ];
    logic [IW-1:0]        pick_c;
    logic                 any_req_c;
    logic                 space_ok_c;
    logic                 ack_c;
    logic                 last_beat_c;
    logic [NREQ-1:0]      ack_vec_c;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (i_req),
        .last      (grant_q),
        .nxt_c     (pick_c),
        .any_req_c (any_req_c)
    );

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            word_c[k] = i_data[k*BW +: BW];
        end
    end

    // The write committed at this edge still occupies a slot the fill count has not seen yet.
    assign space_ok_c  = !i_fifo_full &&
                         ((SW'(i_fifo_fill) + SW'(wr_q)) < SW'(DEPTH));
    assign ack_c       = (state_q == GRANT) && i_req[grant_q] && space_ok_c;
    assign last_beat_c = (burst_q + BURST_W'(1)) == BURST_W'(MAXBURST);

    always_comb begin
        ack_vec_c = '0;
        if (ack_c) begin
            ack_vec_c[grant_q] = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    grant_d = pick_c;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (ack_c) begin
                    wr_d    = 1'b1;
                    data_d  = word_c[grant_q];
                    burst_d = burst_q + BURST_W'(1);
                    if (last_beat_c) begin
                        state_d = IDLE;
                    end
                end
                if (!i_req[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            grant_q <= IW'(NREQ - 1);
            burst_q <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    assign o_ack       = ack_vec_c;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q == GRANT);
    assign o_fifo_wr   = wr_q;
    assign o_fifo_data = data_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter with a FIFO model and requester scoreboard.
module tb_fifo_wr_arbiter;

    localparam int unsigned BW     = 8;
    localparam int unsigned LGFLEN = 4;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned MAXB   = 4;
    localparam int          DEPTH  = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*BW-1:0]  data;
    logic [NREQ-1:0]     ack;
    logic [1:0]          grant;
    logic                busy;
    logic                fifo_wr;
    logic [BW-1:0]       fifo_data;
    logic [LGFLEN:0]     fill;
    logic                full;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .BW(BW), .LGFLEN(LGFLEN), .NREQ(NREQ), .MAXBURST(MAXB)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_req       (req),
        .i_data      (data),
        .o_ack       (ack),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_fifo_wr   (fifo_wr),
        .o_fifo_data (fifo_data),
        .i_fifo_fill (fill),
        .i_fifo_full (full)
    );

    int total = 0;
    int bad   = 0;

    // Reference scheduler state
    bit          m_busy;
    int          m_owner;
    int          m_cnt;
    bit          m_wr;
    logic [7:0]  m_data;
    int          grant_log[$];

    // Requesters, FIFO model and scoreboard
    logic [7:0]      src [NREQ][$];
    int              ptr  [NREQ];
    int              wptr [NREQ];
    int              sq   [NREQ];
    bit              en   [NREQ];
    bit              rand_en;
    int              fifo_cnt;
    int              drain_mode;
    int              pop_once;
    bit              push_pend;
    logic [7:0]      push_data;
    logic [NREQ-1:0] ack_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic add_words(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            src[k].push_back({2'(k), 6'(sq[k])});
            sq[k]++;
        end
    endtask

    task automatic drive();
        logic [NREQ-1:0]    nreq;
        logic [NREQ*BW-1:0] ndata;
        nreq  = '0;
        ndata = '0;
        for (int k = 0; k < NREQ; k++) begin
            bit held;
            bit have;
            held = req[k] && !ack_seen[k];
            if (rand_en && !held) en[k] = ($urandom_range(0, 3) != 0);
            have = ptr[k] < src[k].size();
            nreq[k] = have && (en[k] || held);
            if (have) ndata[k*8 +: 8] = src[k][ptr[k]];
        end
        req  = nreq;
        data = ndata;
        fill = 5'(fifo_cnt);
        full = (fifo_cnt >= DEPTH);
    endtask

    // Compare outputs against the reference, then advance it across the coming edge.
    task automatic model_cycle();
        logic [NREQ-1:0] exp_ack;
        bit space;
        space   = (fifo_cnt < DEPTH) && ((fifo_cnt + int'(m_wr)) < DEPTH);
        exp_ack = '0;
        if (m_busy && req[m_owner] && space) exp_ack[m_owner] = 1'b1;
        chk("ack", ack, exp_ack);
        chk("busy", busy, m_busy);
        chk("grant", grant, m_owner);
        chk("fifo_wr", fifo_wr, m_wr);
        if (m_wr) chk("fifo_data", fifo_data, m_data);
        ack_seen  = ack & req;
        push_pend = fifo_wr;
        push_data = fifo_data;
        if (!m_busy) begin
            m_wr = 1'b0;
            if (req != '0) begin
                for (int d = NREQ; d >= 1; d--) begin
                    if (req[(m_owner + d) % NREQ]) m_cnt = (m_owner + d) % NREQ;
                end
                m_owner = m_cnt;
                m_cnt   = 0;
                m_busy  = 1'b1;
                grant_log.push_back(m_owner);
            end
        end else begin
            m_wr = (exp_ack != '0);
            if (m_wr) begin
                m_data = data[m_owner*8 +: 8];
                m_cnt++;
                if (m_cnt == MAXB) m_busy = 1'b0;
            end
            if (!req[m_owner]) m_busy = 1'b0;
        end
    endtask

    task automatic edge_effects();
        if (push_pend) begin
            int id;
            chk("no_overflow", 32'(fifo_cnt < DEPTH), 32'd1);
            fifo_cnt++;
            id = int'(push_data[7:6]);
            chk("wr_in_range", 32'(wptr[id] < src[id].size()), 32'd1);
            if (wptr[id] < src[id].size()) chk("wr_word", push_data, src[id][wptr[id]]);
            wptr[id]++;
            push_pend = 1'b0;
        end
        if (pop_once > 0 && fifo_cnt > 0) begin
            fifo_cnt--;
            pop_once--;
        end else if (fifo_cnt > 0 && (drain_mode == 1 ||
                     (drain_mode == 2 && $urandom_range(0, 2) == 0))) begin
            fifo_cnt--;
        end
        for (int k = 0; k < NREQ; k++) if (ack_seen[k]) ptr[k]++;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        edge_effects();
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_fifo_wr", fifo_wr, 1'b0);
        chk("rst_fifo_data", fifo_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_grant", grant, 2'd3);
        m_busy = 1'b0; m_owner = NREQ - 1; m_cnt = 0; m_wr = 1'b0; m_data = '0;
        ack_seen = '0; push_pend = 1'b0;
        grant_log.delete();
        drive();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; req = '0; data = '0; ack_seen = '0;
        rand_en = 1'b0; fifo_cnt = 0; drain_mode = 0; pop_once = 0;
        for (int k = 0; k < NREQ; k++) begin
            ptr[k] = 0; wptr[k] = 0; sq[k] = 0; en[k] = 1'b0;
        end
        sq[0] = 16;
        drive();
        #1;
        do_reset();

        // Lone requester 0 with six words 0x10..0x15: burst of 4, IDLE gap, then 2
        add_words(0, 6);
        en[0] = 1'b1;
        drive();
        run(14);
        chk("s1_ngrants", grant_log.size(), 2);
        for (int i = 0; i < 2; i++) chk("s1_grant", (i < grant_log.size()) ? grant_log[i] : -1, 0);
        chk("s1_written", wptr[0], 6);

        // All four requesting: strict rotation 0,1,2,3,0 after reset
        fifo_cnt = 0;
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            add_words(k, 8);
            en[k] = 1'b1;
        end
        drain_mode = 1;
        drive();
        run(25);
        for (int i = 0; i < 5; i++)
            chk("s2_order", (i < grant_log.size()) ? grant_log[i] : -1, i % NREQ);
        run(30);
        for (int k = 0; k < NREQ; k++) chk("s2_done", wptr[k], src[k].size());

        // Nearly full FIFO: one ack, then stall holding the grant
        for (int k = 0; k < NREQ; k++) en[k] = 1'b0;
        en[2] = 1'b1;
        fifo_cnt = 15;
        drain_mode = 0;
        add_words(2, 4);
        drive();
        run(8);
        chk("s3_one_ack", ptr[2], 9);
        chk("s3_hold_busy", busy, 1'b1);
        chk("s3_hold_grant", grant, 2'd2);
        pop_once = 1;
        run(3);
        chk("s3_resume", ptr[2], 10);
        drain_mode = 1;
        run(12);
        chk("s3_done", ptr[2], 12);

        // Requester 1 finishes after 2 words; pending 3 is served before 0
        for (int k = 0; k < NREQ; k++) en[k] = 1'b0;
        en[0] = 1'b1;
        add_words(0, 1);
        drive();
        run(4);
        grant_log.delete();
        add_words(1, 2); add_words(3, 2); add_words(0, 2);
        en[1] = 1'b1; en[3] = 1'b1;
        drive();
        run(20);
        chk("s4_g0", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
        chk("s4_g1", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
        chk("s4_g2", (grant_log.size() > 2) ? grant_log[2] : -1, 0);

        // Random traffic with random drain, then reset in the middle of a burst
        rand_en = 1'b1;
        drain_mode = 2;
        for (int k = 0; k < NREQ; k++) add_words(k, 20);
        drive();
        run(200);
        rand_en = 1'b0;
        drain_mode = 1;
        for (int k = 0; k < NREQ; k++) begin
            add_words(k, 10);
            en[k] = 1'b1;
        end
        drive();
        for (int i = 0; i < 64 && !m_wr; i++) step();
        chk("pre_reset_wr", fifo_wr, 1'b1);
        if (m_wr) wptr[int'(m_data[7:6])]++;
        do_reset();
        run(3);
        chk("post_reset_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        run(300);
        for (int k = 0; k < NREQ; k++) begin
            chk("final_acked", ptr[k], src[k].size());
            chk("final_written", wptr[k], src[k].size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
